// File: rtl/cnna_mul_pkg.sv
// Shared helpers for the signed x unsigned multiplier pipe: product width, rounding constant, output range.
// No logic and no latency; this file holds only constants and functions.
// Build option CNNA_MUL_SAT_EN uses dout_max/dout_min as the clamp bounds.
package cnna_mul_pkg;

  localparam int DOUT_W_DEF = 16;

  // Full product width: signed a times zero-extended b needs one extra bit.
  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w + 1;
  endfunction

  // Half an LSB of the shifted result; adding it before >>> rounds half toward +inf.
  function automatic longint rnd_const(input int shift);
    if (shift > 0) begin
      return longint'(1) << (shift - 1);
    end
    return longint'(0);
  endfunction

  function automatic longint dout_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint dout_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

  localparam longint DOUT_MAX = dout_max(DOUT_W_DEF);
  localparam longint DOUT_MIN = dout_min(DOUT_W_DEF);

endpackage

// File: rtl/cnna_mul_lane.sv
// One lane datapath: product, round-shift, narrow (wrap, or clamp with CNNA_MUL_SAT_EN), then a delay chain.
// Latency NUM_STAGE registers; the product register is stage 0 whenever NUM_STAGE > 1.
// Stalls come only through i_ld. Each stage loads only when its own load enable is set.
module cnna_mul_lane
  import cnna_mul_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 13,
  parameter int DOUT_W    = 16,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_STAGE-1:0] i_ld,
  input  logic [A_W-1:0]       i_a,
  input  logic [B_W-1:0]       i_b,
  output logic [DOUT_W-1:0]    o_dout,
  output logic                 o_ovf
);

  localparam int PW = prod_w(A_W, B_W);
  // Index of the first result register. With one stage, the whole datapath feeds it directly.
  localparam int RS = (NUM_STAGE > 1) ? 1 : 0;
  localparam int ND = NUM_STAGE - RS;
  localparam logic signed [PW-1:0] RND = PW'(rnd_const(SHIFT));

  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_src;
  logic signed [PW-1:0] w_sum;
  logic signed [PW-1:0] w_r;
  logic [DOUT_W-1:0]    w_dat;
  logic [DOUT_W-1:0]    r_dat [ND];

  // Zero-extending b before the signed multiply keeps it non-negative.
  assign w_p = PW'($signed(i_a)) * $signed(PW'(i_b));

  if (NUM_STAGE > 1) begin : g_preg
    logic signed [PW-1:0] r_p;
    // Product register. It loads only with a valid beat.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_p <= '0;
      end else if (i_ld[0]) begin
        r_p <= w_p;
      end
    end
    assign w_src = r_p;
  end else begin : g_nopreg
    assign w_src = w_p;
  end

  // The rounding add cannot overflow PW bits, because the product never reaches the top bit.
  assign w_sum = w_src + RND;
  assign w_r   = w_sum >>> SHIFT;

`ifdef CNNA_MUL_SAT_EN
  localparam longint DMAX = dout_max(DOUT_W);
  localparam longint DMIN = dout_min(DOUT_W);
  logic signed [63:0] w_r64;
  logic               w_ovf;
  logic               r_ovf [ND];

  assign w_r64 = 64'(w_r);

  // Clamp to the signed output range and flag any lane that was clamped.
  always_comb begin
    w_dat = DOUT_W'(w_r);
    w_ovf = 1'b0;
    if (w_r64 > DMAX) begin
      w_dat = DOUT_W'(DMAX);
      w_ovf = 1'b1;
    end else if (w_r64 < DMIN) begin
      w_dat = DOUT_W'(DMIN);
      w_ovf = 1'b1;
    end
  end

  // The overflow flag travels with its beat through the delay chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ND; k++) r_ovf[k] <= 1'b0;
    end else begin
      if (i_ld[RS]) r_ovf[0] <= w_ovf;
      for (int k = 1; k < ND; k++) begin
        if (i_ld[RS+k]) r_ovf[k] <= r_ovf[k-1];
      end
    end
  end
  assign o_ovf = r_ovf[ND-1];
`else
  // Two's-complement wrap: keep the low DOUT_W bits.
  assign w_dat = DOUT_W'(w_r);
  assign o_ovf = 1'b0;
`endif

  // Result register followed by plain delay stages, which make up the remaining latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < ND; k++) r_dat[k] <= '0;
    end else begin
      if (i_ld[RS]) r_dat[0] <= w_dat;
      for (int k = 1; k < ND; k++) begin
        if (i_ld[RS+k]) r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign o_dout = r_dat[ND-1];

endmodule

// File: rtl/cnna_mul_pipe_sxu.sv
// LANES-wide pipelined signed x unsigned multiplier with round-shift and narrowing (CNNA_MUL_SAT_EN clamps).
// Latency NUM_STAGE cycles at 1 beat/cycle. A beat accepted at edge k appears after edge k+NUM_STAGE-1.
// The whole pipe advances only when ce=1 and the output slot is empty or being taken; in_ready mirrors that.
module cnna_mul_pipe_sxu
  import cnna_mul_pkg::*;
#(
  parameter int LANES     = 1,
  parameter int A_W       = 16,
  parameter int B_W       = 13,
  parameter int DOUT_W    = 16,
  parameter int SHIFT     = 0,
  parameter int NUM_STAGE = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*A_W-1:0]    din0,
  input  logic [LANES*B_W-1:0]    din1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DOUT_W-1:0] dout,
  output logic [LANES-1:0]        ovf
);

  logic [NUM_STAGE-1:0] r_vld;
  logic [NUM_STAGE-1:0] w_ld;
  logic                 w_adv;

  assign w_adv     = ce & (~r_vld[NUM_STAGE-1] | out_ready);
  assign in_ready  = w_adv;
  assign out_valid = r_vld[NUM_STAGE-1];

  // Each stage loads data only when the pipe advances and the beat moving into it is valid.
  always_comb begin
    w_ld    = '0;
    w_ld[0] = w_adv & in_valid;
    for (int s = 1; s < NUM_STAGE; s++) begin
      w_ld[s] = w_adv & r_vld[s-1];
    end
  end

  // Valid shift register. Reset takes priority over ce and drops every beat in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld[0] <= in_valid;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_vld[s] <= r_vld[s-1];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cnna_mul_lane #(
      .A_W      (A_W),
      .B_W      (B_W),
      .DOUT_W   (DOUT_W),
      .SHIFT    (SHIFT),
      .NUM_STAGE(NUM_STAGE)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .i_ld  (w_ld),
      .i_a   (din0[i*A_W +: A_W]),
      .i_b   (din1[i*B_W +: B_W]),
      .o_dout(dout[i*DOUT_W +: DOUT_W]),
      .o_ovf (ovf[i])
    );
  end

endmodule
